// File: rtl/igen_pkg.sv
// Shared opcodes, immediate-format enum and widths for the igen immediate generator.
package igen_pkg;

    localparam int unsigned INSN_W    = 32;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned ILL_CNT_W = 16;

    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    // Buffered entry at the widest legal configuration; igen_pipe narrows it to XLEN/TAG_W.
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned TAG_MAX  = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic                illegal;
        logic [TAG_MAX-1:0]  tag;
    } entry_max_t;

endpackage

// File: rtl/igen_if.sv
// Handshake bus between fetch, the immediate generator and decode.
interface igen_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned DEPTH = 2
);
    import igen_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [INSN_W-1:0] insn_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   imm_o;
    imm_fmt_e          fmt_o;
    logic [TAG_W-1:0]  tag_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output in_valid_i, insn_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, illegal_o, count_o
    );

    modport slave (
        input  in_valid_i, insn_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, illegal_o, count_o
    );

endinterface

// File: rtl/igen_decode.sv
// Combinational RV32I immediate extraction and sign extension to XLEN.
// IGEN_ILLEGAL_CNT_EN adds the illegal-opcode flag output.
module igen_decode
    import igen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSN_W-1:0] insn,
    output logic [XLEN-1:0]   imm,
    output imm_fmt_e          fmt
`ifdef IGEN_ILLEGAL_CNT_EN
   ,output logic              illegal
`endif
);

    logic [31:0] imm32;

    // Build the 32-bit immediate; widening to XLEN is a single sign extension below.
    always_comb begin
        imm32 = '0;
        fmt   = FMT_NONE;
        case (insn[OPC_W-1:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                imm32 = {{20{insn[31]}}, insn[31:20]};
                fmt   = FMT_I;
            end
            OP_STORE: begin
                imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
                fmt   = FMT_S;
            end
            OP_BRANCH: begin
                imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {insn[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OP_JAL: begin
                imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OP_REG: begin
                fmt   = FMT_R;
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

`ifdef IGEN_ILLEGAL_CNT_EN
    assign illegal = (fmt == FMT_NONE);
`endif

endmodule

// File: rtl/igen_pipe.sv
// Immediate generator with a DEPTH-entry output FIFO between fetch and decode.
// IGEN_ILLEGAL_CNT_EN keeps the illegal flag in the buffer and adds illegal_cnt_o.
module igen_pipe
    import igen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    igen_if.slave                bus
`ifdef IGEN_ILLEGAL_CNT_EN
   ,output logic [ILL_CNT_W-1:0] illegal_cnt_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Narrowed form of entry_max_t so no unused bits are stored.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
`ifdef IGEN_ILLEGAL_CNT_EN
        logic             illegal;
`endif
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
`ifdef IGEN_ILLEGAL_CNT_EN
    logic             dec_illegal;
`endif

    igen_decode #(.XLEN(XLEN)) u_decode (
        .insn    (bus.insn_i),
        .imm     (dec_imm),
        .fmt     (dec_fmt)
`ifdef IGEN_ILLEGAL_CNT_EN
       ,.illegal (dec_illegal)
`endif
    );

    always_comb begin
        wr_entry         = '0;
        wr_entry.imm     = dec_imm;
        wr_entry.fmt     = dec_fmt;
`ifdef IGEN_ILLEGAL_CNT_EN
        wr_entry.illegal = dec_illegal;
`endif
        wr_entry.tag     = bus.tag_i;
    end

    // Ready depends only on registered occupancy, never on out_ready_i.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = bus.in_valid_i && in_ready;
    assign pop       = out_valid && bus.out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef IGEN_ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_o <= '0;
        end else if (push && dec_illegal && (illegal_cnt_o != '1)) begin
            illegal_cnt_o <= illegal_cnt_o + ILL_CNT_W'(1);
        end
    end
`endif

    assign head            = mem[rd_ptr];
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.imm_o       = head.imm;
    assign bus.fmt_o       = head.fmt;
    assign bus.tag_o       = head.tag;
    assign bus.count_o     = count;
`ifdef IGEN_ILLEGAL_CNT_EN
    assign bus.illegal_o   = head.illegal;
`else
    assign bus.illegal_o   = 1'b0;
`endif

endmodule

// File: tb/tb_igen_pipe.sv
// Directed bench for igen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_igen_pipe;
    import igen_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef IGEN_ILLEGAL_CNT_EN
    localparam logic ILL_EXP = 1'b1;
    logic [15:0] ill_cnt32;
    logic [15:0] ill_cnt64;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    igen_if #(.XLEN(32), .TAG_W(32), .DEPTH(2)) bus32 ();
    igen_if #(.XLEN(64), .TAG_W(32), .DEPTH(2)) bus64 ();

    igen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut32 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus32)
`ifdef IGEN_ILLEGAL_CNT_EN
       ,.illegal_cnt_o (ill_cnt32)
`endif
    );

    igen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus64)
`ifdef IGEN_ILLEGAL_CNT_EN
       ,.illegal_cnt_o (ill_cnt64)
`endif
    );

    logic [31:0] f_insn [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'h001000EF};
    logic [31:0] f_imm  [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [2:0]  f_fmt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] w_insn [2] = '{32'hFFF00093, 32'h800000B7};
    logic [63:0] w_imm  [2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000};

    task automatic set_in(input logic v, input logic [31:0] insn, input logic [31:0] tag, input logic rdy);
        bus32.in_valid_i  = v;   bus64.in_valid_i  = v;
        bus32.insn_i      = insn; bus64.insn_i     = insn;
        bus32.tag_i       = tag; bus64.tag_i       = tag;
        bus32.out_ready_i = rdy; bus64.out_ready_i = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        n_total++; if (bus32.out_valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus32.out_valid_o); else n_pass++;
        n_total++; if (bus32.in_ready_o !== 1'b1) $display("FAIL rst_ready: got %b exp 1", bus32.in_ready_o); else n_pass++;
        n_total++; if (bus32.count_o !== 2'd0) $display("FAIL rst_count: got %0d exp 0", bus32.count_o); else n_pass++;
        n_total++; if (bus32.imm_o !== 32'h0) $display("FAIL rst_imm: got %h exp 0", bus32.imm_o); else n_pass++;
        n_total++; if (bus32.fmt_o !== 3'd0) $display("FAIL rst_fmt: got %0d exp 0", bus32.fmt_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'h0) $display("FAIL rst_tag: got %h exp 0", bus32.tag_o); else n_pass++;
        n_total++; if (bus32.illegal_o !== 1'b0) $display("FAIL rst_illegal: got %b exp 0", bus32.illegal_o); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_formats();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1'b1, f_insn[i], 32'(i + 16), 1'b1);
            n_total++; if (bus32.out_valid_o !== 1'b0) $display("FAIL fmt%0d_no_bypass: got %b exp 0", i, bus32.out_valid_o); else n_pass++;
            @(negedge clk);
            set_in(1'b0, 32'h0, 32'h0, 1'b1);
            n_total++; if (bus32.out_valid_o !== 1'b1) $display("FAIL fmt%0d_valid: got %b exp 1", i, bus32.out_valid_o); else n_pass++;
            n_total++; if (bus32.imm_o !== f_imm[i]) $display("FAIL fmt%0d_imm: got %h exp %h", i, bus32.imm_o, f_imm[i]); else n_pass++;
            n_total++; if (bus32.fmt_o !== f_fmt[i]) $display("FAIL fmt%0d_fmt: got %0d exp %0d", i, bus32.fmt_o, f_fmt[i]); else n_pass++;
            n_total++; if (bus32.tag_o !== 32'(i + 16)) $display("FAIL fmt%0d_tag: got %0d exp %0d", i, bus32.tag_o, i + 16); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd0) $display("FAIL fmt_drain_count: got %0d exp 0", bus32.count_o); else n_pass++;
    endtask

    task automatic test_xlen64();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1'b1, w_insn[i], 32'(i + 32), 1'b1);
            @(negedge clk);
            set_in(1'b0, 32'h0, 32'h0, 1'b1);
            n_total++; if (bus64.out_valid_o !== 1'b1) $display("FAIL x64_%0d_valid: got %b exp 1", i, bus64.out_valid_o); else n_pass++;
            n_total++; if (bus64.imm_o !== w_imm[i]) $display("FAIL x64_%0d_imm: got %h exp %h", i, bus64.imm_o, w_imm[i]); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        set_in(1'b1, 32'h00100093, 32'd1, 1'b0);
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd1) $display("FAIL bp_count1: got %0d exp 1", bus32.count_o); else n_pass++;
        n_total++; if (bus32.in_ready_o !== 1'b1) $display("FAIL bp_ready1: got %b exp 1", bus32.in_ready_o); else n_pass++;
        set_in(1'b1, 32'h00200093, 32'd2, 1'b0);
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd2) $display("FAIL bp_count2: got %0d exp 2", bus32.count_o); else n_pass++;
        n_total++; if (bus32.in_ready_o !== 1'b0) $display("FAIL bp_full_ready: got %b exp 0", bus32.in_ready_o); else n_pass++;
        set_in(1'b1, 32'h00300093, 32'd3, 1'b0);
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd2) $display("FAIL bp_held_count: got %0d exp 2", bus32.count_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'd1) $display("FAIL bp_stable_tag: got %0d exp 1", bus32.tag_o); else n_pass++;
        n_total++; if (bus32.imm_o !== 32'd1) $display("FAIL bp_stable_imm: got %h exp 1", bus32.imm_o); else n_pass++;
        set_in(1'b1, 32'h00300093, 32'd3, 1'b1);
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd1) $display("FAIL bp_pop1_count: got %0d exp 1", bus32.count_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'd2) $display("FAIL bp_pop1_tag: got %0d exp 2", bus32.tag_o); else n_pass++;
        n_total++; if (bus32.in_ready_o !== 1'b1) $display("FAIL bp_pop1_ready: got %b exp 1", bus32.in_ready_o); else n_pass++;
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        n_total++; if (bus32.count_o !== 2'd1) $display("FAIL bp_pushpop_count: got %0d exp 1", bus32.count_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'd3) $display("FAIL bp_pushpop_tag: got %0d exp 3", bus32.tag_o); else n_pass++;
        n_total++; if (bus32.imm_o !== 32'd3) $display("FAIL bp_pushpop_imm: got %h exp 3", bus32.imm_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd0) $display("FAIL bp_empty_count: got %0d exp 0", bus32.count_o); else n_pass++;
        n_total++; if (bus32.out_valid_o !== 1'b0) $display("FAIL bp_empty_valid: got %b exp 0", bus32.out_valid_o); else n_pass++;
    endtask

    task automatic test_illegal();
        @(negedge clk);
`ifdef IGEN_ILLEGAL_CNT_EN
        n_total++; if (ill_cnt32 !== 16'd0) $display("FAIL ill_cnt_before: got %0d exp 0", ill_cnt32); else n_pass++;
`endif
        set_in(1'b1, 32'h0000007F, 32'hAA, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus32.fmt_o !== 3'd7) $display("FAIL ill_fmt: got %0d exp 7", bus32.fmt_o); else n_pass++;
        n_total++; if (bus32.imm_o !== 32'h0) $display("FAIL ill_imm: got %h exp 0", bus32.imm_o); else n_pass++;
        n_total++; if (bus32.illegal_o !== ILL_EXP) $display("FAIL ill_flag: got %b exp %b", bus32.illegal_o, ILL_EXP); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'hAA) $display("FAIL ill_tag: got %h exp aa", bus32.tag_o); else n_pass++;
`ifdef IGEN_ILLEGAL_CNT_EN
        n_total++; if (ill_cnt32 !== 16'd1) $display("FAIL ill_cnt_after: got %0d exp 1", ill_cnt32); else n_pass++;
`endif
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        n_total++; if (bus32.out_valid_o !== 1'b0) $display("FAIL ill_popped: got %b exp 0", bus32.out_valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_in(1'b1, 32'h00500093, 32'h10, 1'b0);
        @(negedge clk);
        set_in(1'b1, 32'h00600093, 32'h11, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus32.count_o !== 2'd2) $display("FAIL mid_prefill: got %0d exp 2", bus32.count_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus32.out_valid_o !== 1'b0) $display("FAIL mid_valid: got %b exp 0", bus32.out_valid_o); else n_pass++;
        n_total++; if (bus32.count_o !== 2'd0) $display("FAIL mid_count: got %0d exp 0", bus32.count_o); else n_pass++;
        n_total++; if (bus32.in_ready_o !== 1'b1) $display("FAIL mid_ready: got %b exp 1", bus32.in_ready_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'h0) $display("FAIL mid_tag: got %h exp 0", bus32.tag_o); else n_pass++;
`ifdef IGEN_ILLEGAL_CNT_EN
        n_total++; if (ill_cnt32 !== 16'd0) $display("FAIL mid_ill_cnt: got %0d exp 0", ill_cnt32); else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_in(1'b1, 32'h123450B7, 32'h55, 1'b1);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        n_total++; if (bus32.imm_o !== 32'h12345000) $display("FAIL mid_next_imm: got %h exp 12345000", bus32.imm_o); else n_pass++;
        n_total++; if (bus32.tag_o !== 32'h55) $display("FAIL mid_next_tag: got %h exp 55", bus32.tag_o); else n_pass++;
        n_total++; if (bus32.count_o !== 2'd1) $display("FAIL mid_next_count: got %0d exp 1", bus32.count_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus32.count_o !== 2'd0) $display("FAIL mid_drain: got %0d exp 0", bus32.count_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_xlen64();
        test_back_pressure();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
